// File: rtl/vga_plot_if.sv
// Pixel-write bus shared between the drawing engines and the plot arbiter.
// Handshake: an engine holds req[i] high for its whole burst; a pixel is
// accepted on any cycle where grant[i], req[i] and plot_in[i] are all high,
// and done[i] marks the last accepted pixel. The registered pixel
// (x_out/y_out/color_out with plot_out) reaches the adapter one cycle later.
interface vga_plot_if #(
  parameter int N = 4
) ();
  logic [N-1:0]   req;
  logic [N-1:0]   done;
  logic [9*N-1:0] x_in;
  logic [8*N-1:0] y_in;
  logic [3*N-1:0] color_in;
  logic [N-1:0]   plot_in;
  logic [N-1:0]   grant;
  logic           busy;
  logic           timeout;
  logic [8:0]     x_out;
  logic [7:0]     y_out;
  logic [2:0]     color_out;
  logic           plot_out;
  logic [1:0]     dbg_state;

  // Engine side: drives requests and pixels, observes the arbiter.
  modport master (
    output req, done, x_in, y_in, color_in, plot_in,
    input  grant, busy, timeout, x_out, y_out, color_out, plot_out, dbg_state
  );

  // Arbiter side.
  modport slave (
    input  req, done, x_in, y_in, color_in, plot_in,
    output grant, busy, timeout, x_out, y_out, color_out, plot_out, dbg_state
  );
endinterface

// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter sharing the vga_adapter pixel port among N drawing
// engines. One engine owns the port per grant, streams pixels until done,
// a dropped request, or the per-grant pixel limit, then a one-cycle gap
// and re-arbitration starting just after the previous owner.
module vga_plot_arbiter #(
  parameter int N         = 4,
  parameter int MAX_GRANT = 76800,
  parameter int CNT_W     = 17
) (
  input logic       clk,
  input logic       reset_n,
  vga_plot_if.slave bus
);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_GRANT);
  localparam logic [IDX_W:0]   N_W      = (IDX_W+1)'(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N-1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t           r_state, w_state_nx;
  logic [N-1:0]     r_grant, w_grant_nx;
  logic             r_busy, w_busy_nx;
  logic             r_timeout, w_timeout_nx;
  logic [8:0]       r_x, w_x_nx;
  logic [7:0]       r_y, w_y_nx;
  logic [2:0]       r_c, w_c_nx;
  logic             r_plot, w_plot_nx;
  logic [IDX_W-1:0] r_ptr, w_ptr_nx;
  logic [IDX_W-1:0] r_owner, w_owner_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;

  logic [N-1:0]     w_rot;
  logic [IDX_W-1:0] w_off;
  logic [IDX_W:0]   w_sum;
  logic [IDX_W-1:0] w_sel;
  logic             w_any;

  logic             w_req_g, w_plot_g, w_done_g, w_fwd, w_cnt_hit;
  logic [8:0]       w_x_g;
  logic [7:0]       w_y_g;
  logic [2:0]       w_c_g;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [IDX_W-1:0] w_ptr_after;

  // Round-robin pick: rotate requests so the pointer lands on bit 0, take
  // the lowest set bit, then rotate the offset back modulo N.
  always_comb begin
    w_rot = N'({bus.req, bus.req} >> r_ptr);
    w_off = '0;
    for (int k = N-1; k >= 0; k--) begin
      if (w_rot[k]) w_off = IDX_W'(k);
    end
    w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    if (w_sum >= N_W) w_sum = w_sum - N_W;
    w_sel = w_sum[IDX_W-1:0];
    w_any = |bus.req;
  end

  // Owner's lane of the packed request/pixel buses; other lanes are ignored.
  always_comb begin
    w_req_g  = 1'b0;
    w_plot_g = 1'b0;
    w_done_g = 1'b0;
    w_x_g    = '0;
    w_y_g    = '0;
    w_c_g    = '0;
    for (int k = 0; k < N; k++) begin
      if (r_owner == IDX_W'(k)) begin
        w_req_g  = bus.req[k];
        w_plot_g = bus.plot_in[k];
        w_done_g = bus.done[k];
        w_x_g    = bus.x_in[9*k +: 9];
        w_y_g    = bus.y_in[8*k +: 8];
        w_c_g    = bus.color_in[3*k +: 3];
      end
    end
  end

  // Pixel counting and release helpers for the current owner.
  always_comb begin
    w_fwd       = w_plot_g & w_req_g;
    w_cnt_inc   = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;
    w_cnt_hit   = (MAX_GRANT != 0) && w_fwd && (w_cnt_inc == MAX_CNT);
    w_ptr_after = (r_owner == LAST_IDX) ? '0 : r_owner + 1'b1;
  end

  // Next-state and next-output logic; registers hold unless changed below.
  always_comb begin
    w_state_nx   = r_state;
    w_grant_nx   = r_grant;
    w_busy_nx    = r_busy;
    w_timeout_nx = 1'b0;
    w_plot_nx    = 1'b0;
    w_x_nx       = r_x;
    w_y_nx       = r_y;
    w_c_nx       = r_c;
    w_ptr_nx     = r_ptr;
    w_owner_nx   = r_owner;
    w_cnt_nx     = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nx = S_GRANT;
          w_owner_nx = w_sel;
          w_busy_nx  = 1'b1;
          w_cnt_nx   = '0;
          for (int k = 0; k < N; k++) begin
            w_grant_nx[k] = (w_sel == IDX_W'(k));
          end
        end
      end
      S_GRANT: begin
        w_x_nx    = w_x_g;
        w_y_nx    = w_y_g;
        w_c_nx    = w_c_g;
        w_plot_nx = w_fwd;
        if (w_plot_g) w_cnt_nx = w_cnt_inc;
        // Dropped request beats done, done beats the pixel limit.
        if (!w_req_g || w_done_g || w_cnt_hit) begin
          w_state_nx   = S_GAP;
          w_grant_nx   = '0;
          w_busy_nx    = 1'b0;
          w_ptr_nx     = w_ptr_after;
          w_timeout_nx = w_req_g && !w_done_g && w_cnt_hit;
        end
      end
      S_GAP: begin
        w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_grant   <= '0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_x       <= '0;
      r_y       <= '0;
      r_c       <= '0;
      r_plot    <= 1'b0;
      r_ptr     <= '0;
      r_owner   <= '0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_grant   <= w_grant_nx;
      r_busy    <= w_busy_nx;
      r_timeout <= w_timeout_nx;
      r_x       <= w_x_nx;
      r_y       <= w_y_nx;
      r_c       <= w_c_nx;
      r_plot    <= w_plot_nx;
      r_ptr     <= w_ptr_nx;
      r_owner   <= w_owner_nx;
      r_cnt     <= w_cnt_nx;
    end
  end

  assign bus.grant     = r_grant;
  assign bus.busy      = r_busy;
  assign bus.timeout   = r_timeout;
  assign bus.x_out     = r_x;
  assign bus.y_out     = r_y;
  assign bus.color_out = r_c;
  assign bus.plot_out  = r_plot;
  assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed bench for vga_plot_arbiter: a vector table for single grants and
// foreign-lane isolation, then hand sequences for round-robin, timeout,
// dropped request and mid-burst reset.
module tb_vga_plot_arbiter;
  localparam int N = 4;

  logic clk;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;

  logic [19:0] exp_q[$];
  logic [3:0]  grant_q[$];

  typedef struct {
    logic [3:0] req, done, plot;
    logic [8:0] x0, x3;
    logic [7:0] y0, y3;
    logic [2:0] c0, c3;
    logic [3:0] e_grant;
    logic       e_busy, e_plot, e_to;
    logic [8:0] e_x;
    logic [7:0] e_y;
    logic [2:0] e_c;
  } vec_t;
  vec_t vq[$];

  vga_plot_if #(.N(N)) bus ();

  vga_plot_arbiter #(.N(N), .MAX_GRANT(8), .CNT_W(4)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic [3:0] eg, input logic eb,
                         input logic ep, input logic et);
    chk({tag, ".grant"},   32'(bus.grant),    32'(eg));
    chk({tag, ".busy"},    32'(bus.busy),     32'(eb));
    chk({tag, ".plot"},    32'(bus.plot_out), 32'(ep));
    chk({tag, ".timeout"}, 32'(bus.timeout),  32'(et));
  endtask

  task automatic chk_pix(input string tag, input logic [8:0] ex, input logic [7:0] ey,
                         input logic [2:0] ec);
    chk({tag, ".x"}, 32'(bus.x_out),     32'(ex));
    chk({tag, ".y"}, 32'(bus.y_out),     32'(ey));
    chk({tag, ".c"}, 32'(bus.color_out), 32'(ec));
  endtask

  task automatic set_eng(input int i, input logic [8:0] x, input logic [7:0] y,
                         input logic [2:0] c);
    bus.x_in[9*i +: 9]     = x;
    bus.y_in[8*i +: 8]     = y;
    bus.color_in[3*i +: 3] = c;
  endtask

  task automatic clr_inputs();
    bus.req      = '0;
    bus.done     = '0;
    bus.plot_in  = '0;
    bus.x_in     = '0;
    bus.y_in     = '0;
    bus.color_in = '0;
  endtask

  task automatic av(input logic [3:0] req, input logic [3:0] done, input logic [3:0] plot,
                    input logic [8:0] x0, input logic [7:0] y0, input logic [2:0] c0,
                    input logic [8:0] x3, input logic [7:0] y3, input logic [2:0] c3,
                    input logic [3:0] eg, input logic eb, input logic ep, input logic et,
                    input logic [8:0] ex, input logic [7:0] ey, input logic [2:0] ec);
    vec_t v;
    v.req = req; v.done = done; v.plot = plot;
    v.x0 = x0; v.y0 = y0; v.c0 = c0;
    v.x3 = x3; v.y3 = y3; v.c3 = c3;
    v.e_grant = eg; v.e_busy = eb; v.e_plot = ep; v.e_to = et;
    v.e_x = ex; v.e_y = ey; v.e_c = ec;
    vq.push_back(v);
  endtask

  initial begin
    int   ecnt[4];
    int   gord[5];
    int   pix_seen;
    int   gap;
    logic [3:0]  prev_grant;
    logic [19:0] exp_pix;

    reset_n = 1'b0;
    clr_inputs();

    // Vector table: single burst from 0, then 0 again with lane 3 noise,
    // then lane 3 granted with no leftover effect from its earlier done.
    //  req     done    plot     x0  y0  c0      x3   y3   c3      grant b  p  t   x    y    c
    av(4'b0001, 4'b0000, 4'b0000, 0,  0,  3'd0,  0,   0,   3'd0,  4'b0001,1,0,0, 0,   0,   3'd0);
    av(4'b0001, 4'b0000, 4'b0001, 10, 20, 3'd4,  0,   0,   3'd0,  4'b0001,1,1,0, 10,  20,  3'd4);
    av(4'b0001, 4'b0000, 4'b0001, 10, 20, 3'd4,  0,   0,   3'd0,  4'b0001,1,1,0, 10,  20,  3'd4);
    av(4'b0001, 4'b0001, 4'b0001, 10, 20, 3'd4,  0,   0,   3'd0,  4'b0000,0,1,0, 10,  20,  3'd4);
    av(4'b0000, 4'b0000, 4'b0000, 10, 20, 3'd4,  0,   0,   3'd0,  4'b0000,0,0,0, 10,  20,  3'd4);
    av(4'b0001, 4'b0000, 4'b0000, 10, 20, 3'd4,  0,   0,   3'd0,  4'b0001,1,0,0, 10,  20,  3'd4);
    av(4'b1001, 4'b1000, 4'b1001, 11, 21, 3'd1,  300, 200, 3'd7,  4'b0001,1,1,0, 11,  21,  3'd1);
    av(4'b1001, 4'b0000, 4'b1000, 12, 22, 3'd2,  300, 200, 3'd7,  4'b0001,1,0,0, 12,  22,  3'd2);
    av(4'b1001, 4'b1001, 4'b1001, 13, 23, 3'd3,  301, 201, 3'd6,  4'b0000,0,1,0, 13,  23,  3'd3);
    av(4'b1000, 4'b0000, 4'b0000, 0,  0,  3'd0,  300, 200, 3'd7,  4'b0000,0,0,0, 13,  23,  3'd3);
    av(4'b1000, 4'b1000, 4'b1000, 0,  0,  3'd0,  300, 200, 3'd7,  4'b1000,1,0,0, 13,  23,  3'd3);
    av(4'b1000, 4'b0000, 4'b1000, 0,  0,  3'd0,  300, 200, 3'd7,  4'b1000,1,1,0, 300, 200, 3'd7);
    av(4'b1000, 4'b1000, 4'b1000, 0,  0,  3'd0,  301, 201, 3'd6,  4'b0000,0,1,0, 301, 201, 3'd6);
    av(4'b0000, 4'b0000, 4'b0000, 0,  0,  3'd0,  0,   0,   3'd0,  4'b0000,0,0,0, 301, 201, 3'd6);

    // Reset state
    repeat (3) tick();
    chk_ctl("reset", 4'b0000, 1'b0, 1'b0, 1'b0);
    chk_pix("reset", 9'd0, 8'd0, 3'd0);
    chk("reset.state", 32'(bus.dbg_state), 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      bus.req     = vq[i].req;
      bus.done    = vq[i].done;
      bus.plot_in = vq[i].plot;
      set_eng(0, vq[i].x0, vq[i].y0, vq[i].c0);
      set_eng(3, vq[i].x3, vq[i].y3, vq[i].c3);
      tick();
      chk_ctl($sformatf("vec%0d", i), vq[i].e_grant, vq[i].e_busy, vq[i].e_plot, vq[i].e_to);
      chk_pix($sformatf("vec%0d", i), vq[i].e_x, vq[i].e_y, vq[i].e_c);
    end
    clr_inputs();

    // Round-robin with all four requesting, two pixels per burst.
    gord = '{0, 1, 2, 3, 0};
    for (int j = 0; j < 5; j++) grant_q.push_back(4'(1 << gord[j]));
    for (int j = 0; j < 10; j++) begin
      exp_pix = {9'(gord[j/2]*16 + j%2), 8'(gord[j/2]), 3'(gord[j/2])};
      exp_q.push_back(exp_pix);
    end
    for (int i = 0; i < 4; i++) ecnt[i] = 0;
    bus.req     = 4'b1111;
    bus.plot_in = 4'b1111;
    pix_seen    = 0;
    gap         = 0;
    prev_grant  = bus.grant;
    for (int cyc = 0; cyc < 80 && pix_seen < 10; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.grant[i]) begin
          set_eng(i, 9'(i*16 + ecnt[i]), 8'(i), 3'(i));
          bus.done[i] = (ecnt[i] == 1);
          ecnt[i]++;
        end else begin
          set_eng(i, 9'(i*16), 8'(i), 3'(i));
          bus.done[i] = 1'b0;
          ecnt[i] = 0;
        end
      end
      tick();
      if (bus.grant != 4'b0000 && bus.grant != prev_grant) begin
        if (grant_q.size() == 0) chk("rr.extra_grant", 32'(bus.grant), 32'd0);
        else chk("rr.grant_order", 32'(bus.grant), 32'(grant_q.pop_front()));
      end
      prev_grant = bus.grant;
      if (bus.plot_out) begin
        if (pix_seen > 0) chk($sformatf("rr.gap%0d", pix_seen), 32'(gap), (pix_seen % 2 == 0) ? 32'd2 : 32'd0);
        if (exp_q.size() == 0) chk("rr.extra_pixel", 32'({bus.x_out, bus.y_out, bus.color_out}), 32'd0);
        else chk($sformatf("rr.pixel%0d", pix_seen), 32'({bus.x_out, bus.y_out, bus.color_out}), 32'(exp_q.pop_front()));
        pix_seen++;
        gap = 0;
      end else begin
        gap++;
      end
    end
    chk("rr.pixels_seen", 32'(pix_seen), 32'd10);
    chk("rr.grants_left", 32'(grant_q.size()), 32'd0);
    clr_inputs();
    tick();
    tick();
    chk_ctl("rr.idle", 4'b0000, 1'b0, 1'b0, 1'b0);

    // Pixel limit: lane 2 plots without done, lane 3 waits.
    bus.req     = 4'b1100;
    bus.plot_in = 4'b1100;
    set_eng(2, 9'd100, 8'd0, 3'd2);
    tick();
    chk_ctl("to.grant", 4'b0100, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      set_eng(2, 9'(100 + k), 8'(k), 3'd2);
      tick();
      chk_ctl($sformatf("to.pix%0d", k), (k == 7) ? 4'b0000 : 4'b0100, (k != 7), 1'b1, (k == 7));
      chk_pix($sformatf("to.pix%0d", k), 9'(100 + k), 8'(k), 3'd2);
    end
    tick();
    chk_ctl("to.gap", 4'b0000, 1'b0, 1'b0, 1'b0);
    tick();
    chk_ctl("to.next", 4'b1000, 1'b1, 1'b0, 1'b0);
    clr_inputs();
    tick();
    chk_ctl("to.drop", 4'b0000, 1'b0, 1'b0, 1'b0);
    tick();

    // Lane 1 drops req mid-burst; pointer moves to 2.
    bus.req = 4'b0010;
    tick();
    chk_ctl("drop.grant", 4'b0010, 1'b1, 1'b0, 1'b0);
    bus.plot_in = 4'b0010;
    set_eng(1, 9'd50, 8'd5, 3'd6);
    tick();
    chk_ctl("drop.pix", 4'b0010, 1'b1, 1'b1, 1'b0);
    chk_pix("drop.pix", 9'd50, 8'd5, 3'd6);
    bus.req = 4'b0000;
    set_eng(1, 9'd51, 8'd5, 3'd6);
    tick();
    chk_ctl("drop.release", 4'b0000, 1'b0, 1'b0, 1'b0);
    bus.plot_in = 4'b0000;
    bus.req     = 4'b0101;
    tick();
    chk_ctl("drop.gap", 4'b0000, 1'b0, 1'b0, 1'b0);
    tick();
    chk_ctl("drop.ptr", 4'b0100, 1'b1, 1'b0, 1'b0);
    clr_inputs();
    tick();
    tick();

    // Reset in the middle of a burst.
    bus.req = 4'b0001;
    tick();
    chk_ctl("rst.grant", 4'b0001, 1'b1, 1'b0, 1'b0);
    bus.plot_in = 4'b0001;
    set_eng(0, 9'd77, 8'd7, 3'd5);
    tick();
    tick();
    chk_ctl("rst.burst", 4'b0001, 1'b1, 1'b1, 1'b0);
    chk_pix("rst.burst", 9'd77, 8'd7, 3'd5);
    reset_n     = 1'b0;
    bus.req     = 4'b0010;
    bus.plot_in = 4'b0000;
    tick();
    chk_ctl("rst.abort", 4'b0000, 1'b0, 1'b0, 1'b0);
    chk_pix("rst.abort", 9'd0, 8'd0, 3'd0);
    chk("rst.state", 32'(bus.dbg_state), 32'd0);
    reset_n = 1'b1;
    tick();
    chk_ctl("rst.regrant", 4'b0010, 1'b1, 1'b0, 1'b0);
    bus.plot_in = 4'b0010;
    bus.done    = 4'b0010;
    set_eng(1, 9'd88, 8'd8, 3'd1);
    tick();
    chk_ctl("rst.last", 4'b0000, 1'b0, 1'b1, 1'b0);
    chk_pix("rst.last", 9'd88, 8'd8, 3'd1);
    clr_inputs();
    tick();
    chk_ctl("rst.gap", 4'b0000, 1'b0, 1'b0, 1'b0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
